// File: rtl/shared_response_buffer.sv
// shared_response_buffer: R-beat store keeping per-UID linked lists in one shared slot pool,
// with a per-UID occupancy cap, a complete-burst bitmap and an optional store-and-forward mode.
module shared_response_buffer #(
  parameter int NUM_UIDS          = 16,
  parameter int ID_WIDTH          = 4,
  parameter int DATA_WIDTH        = 64,
  parameter int RESP_WIDTH        = 2,
  parameter int POOL_DEPTH        = 32,
  parameter int MAX_BEATS_PER_UID = 8,
  parameter int STORE_FWD         = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ID_WIDTH-1:0]                in_id,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [RESP_WIDTH-1:0]              in_resp,
  input  logic                               in_last,
  input  logic                               rd_req,
  input  logic [ID_WIDTH-1:0]                rd_uid,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ID_WIDTH-1:0]                out_id,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [RESP_WIDTH-1:0]              out_resp,
  output logic                               out_last,
  output logic [NUM_UIDS-1:0]                burst_ready,
  output logic [$clog2(POOL_DEPTH+1)-1:0]    free_slots
);
  localparam int PW = $clog2(POOL_DEPTH);
  localparam int CW = $clog2(MAX_BEATS_PER_UID + 1);
  localparam int FW = $clog2(POOL_DEPTH + 1);
  localparam int NU = 1 << ID_WIDTH;
  logic [POOL_DEPTH-1:0] free_q, free_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic [PW-1:0]         next_q [POOL_DEPTH];
  logic [PW-1:0]         next_d [POOL_DEPTH];
  logic [PW-1:0]         head_q [NU];
  logic [PW-1:0]         head_d [NU];
  logic [PW-1:0]         tail_q [NU];
  logic [PW-1:0]         tail_d [NU];
  logic [CW-1:0]         cnt_q [NU];
  logic [CW-1:0]         cnt_d [NU];
  logic [CW-1:0]         last_cnt_q [NU];
  logic [CW-1:0]         last_cnt_d [NU];
  logic [DATA_WIDTH-1:0] mem_data [POOL_DEPTH];
  logic [RESP_WIDTH-1:0] mem_resp [POOL_DEPTH];
  logic [POOL_DEPTH-1:0] mem_last;
  logic [NU-1:0]         uid_ok;
  logic [PW-1:0]         slot;
  logic [PW-1:0]         rd_head;
  logic                  accept;
  logic                  pop;
  logic                  readable;
  // Lowest-index free slot; a slot freed this cycle is still marked busy here.
  always_comb begin
    slot = '0;
    for (int i = POOL_DEPTH - 1; i >= 0; i--) slot = free_q[i] ? PW'(i) : slot;
  end
  always_comb begin
    uid_ok = '0;
    for (int u = 0; u < NU; u++) uid_ok[u] = u < NUM_UIDS;
  end
  always_comb begin
    burst_ready = '0;
    for (int u = 0; u < NUM_UIDS; u++) burst_ready[u] = last_cnt_q[u] != '0;
  end
  assign in_ready   = (fcnt_q != '0) && (cnt_q[in_id] != CW'(MAX_BEATS_PER_UID));
  assign accept     = in_valid && in_ready && uid_ok[in_id];
  assign rd_head    = head_q[rd_uid];
  assign readable   = (STORE_FWD != 0) ? (last_cnt_q[rd_uid] != '0) : (cnt_q[rd_uid] != '0);
  assign out_valid  = rd_req && readable;
  assign pop        = out_valid && out_ready;
  assign out_id     = rd_uid;
  assign out_data   = out_valid ? mem_data[rd_head] : '0;
  assign out_resp   = out_valid ? mem_resp[rd_head] : '0;
  assign out_last   = out_valid ? mem_last[rd_head] : 1'b0;
  assign free_slots = fcnt_q;
  always_comb begin
    free_d     = free_q;
    next_d     = next_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    last_cnt_d = last_cnt_q;
    fcnt_d     = fcnt_q - FW'(accept) + FW'(pop);
    if (pop) free_d[rd_head] = 1'b1;
    if (accept) free_d[slot] = 1'b0;
    if (accept && cnt_q[in_id] != '0) next_d[tail_q[in_id]] = slot;
    for (int u = 0; u < NU; u++) begin
      if (pop && rd_uid == ID_WIDTH'(u)) begin
        head_d[u]     = next_q[head_q[u]];
        cnt_d[u]      = cnt_q[u] - CW'(1);
        last_cnt_d[u] = last_cnt_q[u] - CW'(out_last);
      end
      // A count of one after the update means the new beat is the whole list.
      if (accept && in_id == ID_WIDTH'(u)) begin
        tail_d[u]     = slot;
        cnt_d[u]      = cnt_d[u] + CW'(1);
        last_cnt_d[u] = last_cnt_d[u] + CW'(in_last);
        head_d[u]     = (cnt_d[u] == CW'(1)) ? slot : head_d[u];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q     <= '1;
      fcnt_q     <= FW'(POOL_DEPTH);
      next_q     <= '{default: '0};
      head_q     <= '{default: '0};
      tail_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
      last_cnt_q <= '{default: '0};
    end else begin
      free_q     <= free_d;
      fcnt_q     <= fcnt_d;
      next_q     <= next_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      last_cnt_q <= last_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[slot] <= in_data;
      mem_resp[slot] <= in_resp;
      mem_last[slot] <= in_last;
    end
  end
endmodule

// File: tb/tb_shared_response_buffer.sv
// tb_shared_response_buffer: cut-through and store-and-forward instances driven in parallel,
// each checked every cycle against per-UID beat queues.
module tb_shared_response_buffer;
  localparam int NU = 16;
  localparam int PD = 32;
  localparam int MX = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        rd_req = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_id = '0;
  logic [3:0]  rd_uid = '0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_resp = '0;
  logic [1:0]  ir, ov, ol;
  logic [63:0] od [2];
  logic [1:0]  orsp [2];
  logic [3:0]  oid [2];
  logic [15:0] br [2];
  logic [5:0]  fs [2];
  int checks = 0;
  int errors = 0;
  logic [66:0] mq [2*NU][$];
  int tot [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    shared_response_buffer #(.STORE_FWD(g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]), .in_id(in_id),
      .in_data(in_data), .in_resp(in_resp), .in_last(in_last), .rd_req(rd_req),
      .rd_uid(rd_uid), .out_valid(ov[g]), .out_ready(out_ready), .out_id(oid[g]),
      .out_data(od[g]), .out_resp(orsp[g]), .out_last(ol[g]), .burst_ready(br[g]),
      .free_slots(fs[g]));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit has_last(int k);
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i][66]) return 1'b1;
    return 1'b0;
  endfunction

  // Model: one FIFO of {last,resp,data} per UID per instance; readability from queue contents.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2*NU; k++) mq[k].delete();
      tot[0] = 0;
      tot[1] = 0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        int ku, ki;
        bit rdbl, ev, eir;
        logic [66:0] hb;
        logic [15:0] ebr;
        ku = m*NU + int'(rd_uid);
        ki = m*NU + int'(in_id);
        rdbl = (m == 1) ? has_last(ku) : (mq[ku].size() != 0);
        ev = rd_req && rdbl;
        hb = ev ? mq[ku][0] : '0;
        eir = (tot[m] < PD) && (mq[ki].size() != MX);
        for (int u = 0; u < NU; u++) ebr[u] = has_last(m*NU + u);
        chk($sformatf("dut%0d in_ready", m), 64'(ir[m]), 64'(eir));
        chk($sformatf("dut%0d out_valid", m), 64'(ov[m]), 64'(ev));
        chk($sformatf("dut%0d out_data", m), od[m], hb[63:0]);
        chk($sformatf("dut%0d out_resp", m), 64'(orsp[m]), 64'(hb[65:64]));
        chk($sformatf("dut%0d out_last", m), 64'(ol[m]), 64'(hb[66]));
        chk($sformatf("dut%0d out_id", m), 64'(oid[m]), 64'(rd_uid));
        chk($sformatf("dut%0d burst_ready", m), 64'(br[m]), 64'(ebr));
        chk($sformatf("dut%0d free_slots", m), 64'(fs[m]), 64'(PD - tot[m]));
        if (ev && out_ready) begin
          void'(mq[ku].pop_front());
          tot[m]--;
        end
        if (in_valid && eir) begin
          mq[ki].push_back({in_last, in_resp, in_data});
          tot[m]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int id, input logic [63:0] d, input bit l);
    in_valid = 1'b1;
    in_id = 4'(id);
    in_data = d;
    in_resp = d[1:0];
    in_last = l;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async rst free0", 64'(fs[0]), 64'(PD));
    chk("async rst free1", 64'(fs[1]), 64'(PD));
    chk("async rst out_valid", 64'(ov), 64'(0));
    chk("async rst burst_ready", 64'(br[0]), 64'(0));
    in_valid = 1'b0;
    rd_req = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post-reset free", 64'(fs[0]), 64'(PD));
    chk("post-reset in_ready", 64'(ir[0]), 64'(1));
    step();
    // UID 3 burst D0..D3, then drained in order
    for (int i = 0; i < 4; i++) wr(3, 64'hD0 + 64'(i), i == 3);
    @(negedge clk);
    chk("t1 free after 4", 64'(fs[0]), 64'(28));
    chk("t1 burst_ready3", 64'(br[0][3]), 64'(1));
    step();
    rd_req = 1'b1;
    rd_uid = 4'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1 data", od[0], 64'hD0 + 64'(i));
      chk("t1 last", 64'(ol[0]), 64'(i == 3));
      step();
    end
    @(negedge clk);
    chk("t1 free drained", 64'(fs[0]), 64'(PD));
    chk("t1 burst_ready3 clr", 64'(br[0][3]), 64'(0));
    step();
    // store-and-forward withholds UID 5 until its last beat
    rd_uid = 4'd5;
    out_ready = 1'b0;
    wr(5, 64'hA, 1'b0);
    wr(5, 64'hB, 1'b0);
    @(negedge clk);
    chk("t2 sf withheld", 64'(ov[1]), 64'(0));
    chk("t2 ct visible", 64'(ov[0]), 64'(1));
    step();
    wr(5, 64'hC, 1'b1);
    @(negedge clk);
    chk("t2 sf valid", 64'(ov[1]), 64'(1));
    chk("t2 sf head", od[1], 64'hA);
    chk("t2 sf burst_ready5", 64'(br[1][5]), 64'(1));
    step();
    out_ready = 1'b1;
    repeat (3) step();
    rd_req = 1'b0;
    out_ready = 1'b0;
    // interleaved UIDs 1 and 2
    for (int i = 0; i < 4; i++) begin
      wr(1, 64'h100 + 64'(i), i == 3);
      wr(2, 64'h200 + 64'(i), i == 3);
    end
    rd_req = 1'b1;
    out_ready = 1'b1;
    rd_uid = 4'd1;
    repeat (4) step();
    rd_uid = 4'd2;
    repeat (4) step();
    rd_req = 1'b0;
    out_ready = 1'b0;
    // per-UID cap on UID 7
    for (int i = 0; i < 8; i++) wr(7, 64'h700 + 64'(i), i == 7);
    @(negedge clk);
    chk("t4 cap uid7", 64'(ir[0]), 64'(0));
    step();
    in_id = 4'd0;
    @(negedge clk);
    chk("t4 uid0 ready", 64'(ir[0]), 64'(1));
    step();
    in_id = 4'd7;
    rd_req = 1'b1;
    rd_uid = 4'd7;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4 uid7 ready again", 64'(ir[0]), 64'(1));
    step();
    out_ready = 1'b1;
    repeat (7) step();
    rd_req = 1'b0;
    out_ready = 1'b0;
    // full pool, stalled write alongside a pop
    for (int u = 0; u < 4; u++)
      for (int i = 0; i < 8; i++) wr(u, 64'(u*16 + i), i == 7);
    @(negedge clk);
    chk("t5 pool empty", 64'(fs[0]), 64'(0));
    chk("t5 in_ready low", 64'(ir[0]), 64'(0));
    step();
    in_valid = 1'b1;
    in_id = 4'd4;
    in_data = 64'h4444;
    in_last = 1'b1;
    rd_req = 1'b1;
    rd_uid = 4'd0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    rd_req = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5 free after pop", 64'(fs[0]), 64'(1));
    step();
    do_reset();
    // simultaneous pop and write on a one-beat UID
    wr(9, 64'h900, 1'b1);
    in_valid = 1'b1;
    in_id = 4'd9;
    in_data = 64'h901;
    in_resp = 2'd1;
    in_last = 1'b1;
    rd_req = 1'b1;
    rd_uid = 4'd9;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t6 new head valid", 64'(ov[0]), 64'(1));
    chk("t6 new head data", od[0], 64'h901);
    chk("t6 burst_ready9", 64'(br[0][9]), 64'(1));
    step();
    rd_uid = 4'd6;
    wr(6, 64'h600, 1'b0);
    wr(6, 64'h601, 1'b0);
    do_reset();
    // randomized traffic with alternating fill-heavy and drain-heavy phases
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      in_valid = $urandom_range(0, 99) < ((c % 400 < 200) ? 85 : 35);
      in_id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      in_data = {$urandom, $urandom};
      in_resp = 2'($urandom);
      in_last = $urandom_range(0, 2) == 0;
      rd_req = $urandom_range(0, 9) < 7;
      rd_uid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 9) < 6;
      step();
    end
    in_valid = 1'b0;
    rd_req = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shared_response_buffer.md
Name: shared_response_buffer

Overview:
- Second-generation R-beat store for the read-reorder path, sitting between the fabric R channel and the ordering unit.
- Per-UID beats are stored as linked lists in one shared slot pool, so capacity is shared across UIDs instead of being fixed per UID.
- Adds a per-UID occupancy cap, a complete-burst bitmap, and a store-and-forward mode that withholds a UID until its full burst (last beat) has arrived.

Parameters:
NUM_UIDS, 16, number of UIDs (linked lists)
ID_WIDTH, 4, UID width; 2**ID_WIDTH >= NUM_UIDS
DATA_WIDTH, 64, R data width
RESP_WIDTH, 2, R resp width
POOL_DEPTH, 32, total shared beat slots (>=2)
MAX_BEATS_PER_UID, 8, cap on beats held per UID (<= POOL_DEPTH)
STORE_FWD, 0, 0 = cut-through (any stored beat is readable); 1 = beats of a UID are readable only while that UID holds at least one complete burst

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  incoming beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_id  in  ID_WIDTH  UID of the incoming beat
in_data  in  DATA_WIDTH  beat data
in_resp  in  RESP_WIDTH  beat resp
in_last  in  1  last beat of the burst
rd_req  in  1  ordering unit requests the head beat of rd_uid
rd_uid  in  ID_WIDTH  UID to read
out_valid  out  1  head beat of rd_uid presented
out_ready  in  1  pop on out_valid & out_ready
out_id  out  ID_WIDTH  equals rd_uid
out_data  out  DATA_WIDTH  head beat data (0 when !out_valid)
out_resp  out  RESP_WIDTH  head beat resp (0 when !out_valid)
out_last  out  1  head beat last (0 when !out_valid)
burst_ready  out  NUM_UIDS  bit u = UID u holds at least one stored last beat
free_slots  out  clog2(POOL_DEPTH+1)  number of unallocated pool slots

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- State:
  - free bitmap [POOL_DEPTH]; next_ptr[POOL_DEPTH]; slot data/resp/last RAM (not reset).
  - Per UID: head, tail (clog2(POOL_DEPTH) bits), cnt (clog2(MAX_BEATS_PER_UID+1) bits), last_cnt (same width).
- Reset (async, any time including mid-burst):
  - All slots free; all cnt/last_cnt = 0.
  - free_slots = POOL_DEPTH; burst_ready = 0; out_valid = 0; out_data/resp/last = 0.
  - in_ready = 1 once reset is released. Stored beats are discarded.
- in_ready (combinational): (free_slots != 0) && (cnt[in_id] != MAX_BEATS_PER_UID). Does not depend on in_valid.
- Write (accept):
  - The allocated slot is the lowest-index free slot (priority encode), written at the clock edge.
  - If cnt[in_id] == 0: head = tail = slot. Otherwise next_ptr[tail] = slot, tail = slot.
  - cnt++; last_cnt++ if in_last.
- Readability:
  - STORE_FWD=0: cnt[rd_uid] != 0.
  - STORE_FWD=1: last_cnt[rd_uid] != 0.
  - out_valid = rd_req && readable. Data comes combinationally from slot head[rd_uid], so there is zero-cycle latency from rd_req/rd_uid to out_*.
- Pop (out_valid & out_ready):
  - head = next_ptr[head]; cnt--; last_cnt-- if out_last.
  - The head slot returns to the free bitmap at the edge.
- Simultaneous write and pop:
  - Same UID with cnt == 1: the list becomes the new slot (head = tail = new slot), cnt stays 1.
  - Different UIDs: both proceed independently.
  - The freed slot is not eligible for allocation in the same cycle.
  - free_slots next = free_slots - accept + pop.
- Latency: a beat written at edge N is readable from cycle N+1 (cut-through). In STORE_FWD mode it is readable from the cycle after its burst's last beat is written.
- Per-UID ordering: beats leave in arrival order. Multiple bursts of one UID may be queued back-to-back.
- Full pool: in_ready = 0 for all UIDs. The pool is never over-allocated.
- Out-of-range in_id (>= NUM_UIDS) is ignored; in_ready is still driven.
- Reading an empty UID gives out_valid = 0, and nothing changes.
- rd_req/rd_uid may change any cycle. There is no hold requirement on the reader.
- burst_ready[u] = (last_cnt[u] != 0), registered-state derived.
- Counters never wrap: the cap and pool-size checks guarantee this.

Test Plan:
- Reset, then write UID 3 beats D0..D3 with last on D3; rd_req=1, rd_uid=3, out_ready=1 -> out_data D0,D1,D2,D3 on 4 consecutive cycles; out_last only on D3; free_slots 28 -> back to 32; burst_ready[3] 1 -> 0.
- STORE_FWD=1: write UID 5 beats A,B (no last) with rd_req held on UID 5 -> out_valid=0. Write C with last -> out_valid=1 next cycle with A; burst_ready[5]=1.
- Interleaved writes UID1/UID2 alternating, 4 beats each -> each UID drains in its own arrival order. Slots are allocated 0..7 in lowest-free order.
- Fill UID 7 with 8 beats -> in_ready=0 for in_id=7, in_ready=1 for in_id=0. Pop one UID-7 beat -> in_ready for UID 7 returns to 1 next cycle.
- POOL_DEPTH=32 filled across 4 UIDs at 8 each -> free_slots=0, in_ready=0. Write UID 4 and pop UID 0 in the same cycle -> write stalled, free_slots=1 next cycle.
- Pop and write UID 9 in the same cycle with cnt=1 -> cnt stays 1, and the next read returns the new beat. Assert rst mid-burst -> free_slots=32, out_valid=0, burst_ready=0 immediately.
